// File: rtl/reg_dump_streamer.sv
// Streams a framed register dump (header, PC, NUM_REGS words) over a valid/ready byte port.
// Optional trailing XOR checksum byte when DUMP_CHKSUM_EN is defined.
module reg_dump_streamer #(
    parameter int          NUM_REGS = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc_in,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PC, S_SEL, S_CAP, S_BYTES, S_DONE, S_CHK
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;
    logic [4:0]  idx_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
`ifdef DUMP_CHKSUM_EN
    logic [7:0]  chk_q;
`endif

    logic        xfer;
    logic [1:0]  byte_cnt_d;
    logic        last_reg;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    always_comb begin
        xfer       = out_valid_q && out_ready;
        byte_cnt_d = byte_cnt_q + 2'd1;
        last_reg   = (idx_q == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DUMP_CHKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_HDR;
                        pc_q        <= pc_in;
                        out_data_q  <= HDR_BYTE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        byte_cnt_q  <= '0;
`ifdef DUMP_CHKSUM_EN
                        chk_q       <= '0;
`endif
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        state_q    <= S_PC;
                        byte_cnt_q <= '0;
                        out_data_q <= byte_of(pc_q, 2'd0);
                    end
                end
                S_PC: begin
                    if (xfer) begin
`ifdef DUMP_CHKSUM_EN
                        chk_q <= chk_q ^ out_data_q;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            state_q     <= S_SEL;
                            out_valid_q <= 1'b0;
                            idx_q       <= '0;
                        end else begin
                            byte_cnt_q <= byte_cnt_d;
                            out_data_q <= byte_of(pc_q, byte_cnt_d);
                        end
                    end
                end
                S_SEL: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    // Register is read here, not at start, so live updates show up in the dump.
                    state_q     <= S_BYTES;
                    word_q      <= reg_data;
                    out_data_q  <= byte_of(reg_data, 2'd0);
                    out_valid_q <= 1'b1;
                    byte_cnt_q  <= '0;
                end
                S_BYTES: begin
                    if (xfer) begin
`ifdef DUMP_CHKSUM_EN
                        chk_q <= chk_q ^ out_data_q;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            if (!last_reg) begin
                                state_q     <= S_SEL;
                                out_valid_q <= 1'b0;
                                idx_q       <= idx_q + 5'd1;
                            end else begin
`ifdef DUMP_CHKSUM_EN
                                state_q    <= S_CHK;
                                out_data_q <= chk_q ^ out_data_q;
                                out_last_q <= 1'b1;
`else
                                state_q     <= S_DONE;
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
`endif
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_d;
                            out_data_q <= byte_of(word_q, byte_cnt_d);
`ifndef DUMP_CHKSUM_EN
                            out_last_q <= last_reg && (byte_cnt_d == 2'd3);
`endif
                        end
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_sel   = idx_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer: frame content, timing, backpressure, restart and reset cases.
module tb_reg_dump_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc_in = '0;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;

    logic [31:0] rf [32];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];

    int checks = 0;
    int errors = 0;
    int n_bytes, last_pos, last_cyc, first_reg_cyc, stall_bad, sel_bad, frame_done;

    always #5 clk = ~clk;

    assign reg_data = rf[reg_sel];

    reg_dump_streamer #(.NUM_REGS(32), .HDR_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc_in     (pc_in),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [31:0] pc);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int b = 0; b < 4; b++) exp_q.push_back(pc[8*b +: 8]);
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++) exp_q.push_back(rf[r][8*b +: 8]);
`ifdef DUMP_CHKSUM_EN
        x = 8'h00;
        for (int i = 1; i < exp_q.size(); i++) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    // Runs one frame (start already pulsed) and records transferred bytes.
    task automatic collect(input bit toggle, input int restart_cyc, input int rst_byte, input bit poke7);
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        logic [4:0] prev_sel;
        int         n = 0;
        got_q.delete();
        stall_bad = 0; sel_bad = 0; last_pos = -1; last_cyc = -1; first_reg_cyc = -1;
        frame_done = 0;
        prev_sel = reg_sel;
        for (int cyc = 0; cyc < 1000 && frame_done == 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rst = 1'b0;
            out_ready = !toggle || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (cyc == restart_cyc) begin
                start = 1'b1;
                pc_in = 32'hDEADBEEF;
            end
            if (poke7 && n == 10) rf[7] = 32'hCAFEF00D;
            #1;
            if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) stall_bad++;
            if (reg_sel !== prev_sel && reg_sel !== prev_sel + 5'd1 && !(reg_sel == 5'd0 && n <= 5)) sel_bad++;
            prev_sel = reg_sel;
            if (out_valid && out_ready) begin
                if (n == rst_byte) begin
                    rst = 1'b1;
                    frame_done = 1;
                end else begin
                    got_q.push_back(out_data);
                    if (n >= 5 && n < 133 && reg_sel !== 5'((n - 5) / 4)) sel_bad++;
                    if (n == 5) first_reg_cyc = cyc;
                    if (out_last) begin
                        last_pos = n;
                        last_cyc = cyc;
                        frame_done = 1;
                    end
                    n++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        n_bytes = n;
        check("frame_completed", frame_done, 1);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, n_bytes, exp_q.size());
        check({tag, "_last_pos"}, last_pos, exp_q.size() - 1);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_at(i), exp_q[i]);
    endtask

    // Covers DONE (busy still high) and the return to IDLE; optional start in DONE must be ignored.
    task automatic after_frame(input bit start_in_done);
        @(negedge clk);
        start = start_in_done;
        #1 check("busy_in_done", busy, 1);
        @(negedge clk);
        start = 1'b0;
        #1 check("busy_low_after_done", busy, 0);
        check("valid_low_after_done", out_valid, 0);
        @(negedge clk);
        #1 check("done_start_ignored", busy, 0);
    endtask

    task automatic pulse_start(input logic [31:0] pc);
        @(negedge clk);
        pc_in = pc;
        start = 1'b1;
    endtask

    initial begin
        int v;
        for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", reg_sel, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        rst = 1'b0;

        // 1: basic dump with out_ready=1
        pulse_start(32'h00000040);
        collect(1'b0, -1, -1, 1'b0);
        build_exp(32'h00000040);
        compare_frame("basic");
        check("basic_first_reg_cyc", first_reg_cyc, 7);
`ifdef DUMP_CHKSUM_EN
        check("basic_last_cyc", last_cyc, 197);
        check("basic_chksum", got_at(133), 8'h40);
`else
        check("basic_last_cyc", last_cyc, 196);
`endif
        check("basic_sel_seq", sel_bad, 0);
        after_frame(1'b1);

        // 2: backpressure 1,0,0,1
        pulse_start(32'h00000040);
        collect(1'b1, -1, -1, 1'b0);
        compare_frame("bp");
        check("bp_stall_stable", stall_bad, 0);
        check("bp_sel_seq", sel_bad, 0);
        after_frame(1'b0);

        // 3: start while busy is ignored
        pulse_start(32'h00000040);
        collect(1'b0, 20, -1, 1'b0);
        compare_frame("restart");
        after_frame(1'b0);
        v = 0;
        repeat (10) begin
            @(negedge clk);
            #1 if (out_valid || busy) v++;
        end
        check("restart_no_second_frame", v, 0);
        pc_in = 32'h00000040;

        // 4: reset during register 5 byte 2 (stream byte 27)
        pulse_start(32'h00000040);
        collect(1'b0, -1, 27, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sel", reg_sel, 0);
        check("midrst_last", out_last, 0);
        check("midrst_partial_len", n_bytes, 27);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1 check("rst_beats_start", busy, 0);
        pulse_start(32'h00000040);
        collect(1'b0, -1, -1, 1'b0);
        compare_frame("post_rst");
        after_frame(1'b0);

        // 5: reg_sel sequencing and live register read
        pulse_start(32'h00000040);
        collect(1'b0, -1, -1, 1'b1);
        check("sel_seq", sel_bad, 0);
        check("rf7_b0", got_at(33), 8'h0D);
        check("rf7_b1", got_at(34), 8'hF0);
        check("rf7_b2", got_at(35), 8'hFE);
        check("rf7_b3", got_at(36), 8'hCA);
        build_exp(32'h00000040);
        compare_frame("live");
        after_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
